// File: rtl/itype_instr_encoder_pkg.sv
// Shared refcpu definitions for the I-type instruction encoder: opcodes,
// command and state enums, and the I-type field layout.
package itype_instr_encoder_pkg;

   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   typedef enum logic [2:0] {
      CMD_ADDIU = 3'd0,
      CMD_ANDI  = 3'd1,
      CMD_ORI   = 3'd2,
      CMD_XORI  = 3'd3,
      CMD_LUI   = 3'd4,
      CMD_LI    = 3'd5,
      CMD_ILL6  = 3'd6,
      CMD_ILL7  = 3'd7
   } itype_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_HOLD2 = 2'd2
   } enc_state_t;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] imm;
   } itype_fields_t;

   function automatic logic [31:0] makeWord(input logic [5:0] opcode,
                                            input logic [4:0] rs,
                                            input logic [4:0] rt,
                                            input logic [15:0] imm);
      itype_fields_t f;
      f.opcode = opcode;
      f.rs     = rs;
      f.rt     = rt;
      f.imm    = imm;
      return f;
   endfunction

endpackage

// File: rtl/itype_instr_encoder_if.sv
// Command and instruction-word handshake bundle for the I-type encoder.
// master = command source / word sink, slave = encoder.
interface itype_instr_encoder_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [4:0]  cmd_rs;
   logic [4:0]  cmd_rt;
   logic [31:0] cmd_imm;
   logic        cmd_err;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;

   modport master (
      output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_imm, out_ready,
      input  cmd_ready, cmd_err, out_valid, out_instr, out_last
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_imm, out_ready,
      output cmd_ready, cmd_err, out_valid, out_instr, out_last
   );

endinterface

// File: rtl/itype_instr_encoder_li_expander.sv
// Combinational load-immediate expansion: picks the shortest one- or
// two-instruction sequence that builds a 32-bit constant in rt.
module itype_instr_encoder_li_expander
   import itype_instr_encoder_pkg::*;
(
   input  logic [31:0] i_imm,
   input  logic [4:0]  i_rt,
   output logic [1:0]  o_nWords,
   output logic [31:0] o_word0,
   output logic [31:0] o_word1
);

   logic [15:0] w_hi;
   logic [15:0] w_lo;

   assign w_hi = i_imm[31:16];
   assign w_lo = i_imm[15:0];

   // Cheapest form first: zero-extended, pure upper half, sign-extended, then the pair.
   always_comb begin
      o_nWords = 2'd1;
      o_word1  = '0;
      if (w_hi == 16'h0000) begin
         o_word0 = makeWord(OP_ORI, 5'd0, i_rt, w_lo);
      end else if (w_lo == 16'h0000) begin
         o_word0 = makeWord(OP_LUI, 5'd0, i_rt, w_hi);
      end else if (&i_imm[31:15]) begin
         o_word0 = makeWord(OP_ADDIU, 5'd0, i_rt, w_lo);
      end else begin
         o_nWords = 2'd2;
         o_word0  = makeWord(OP_LUI, 5'd0, i_rt, w_hi);
         o_word1  = makeWord(OP_ORI, i_rt, i_rt, w_lo);
      end
   end

endmodule

// File: rtl/itype_instr_encoder.sv
// I-type ALU command to MIPS instruction encoder with a single registered output word.
// Define ITYPE_ENC_LI_EN to enable the two-word LI pseudo-command (state HOLD2).
module itype_instr_encoder (
   input logic clk,
   input logic reset,
   itype_instr_encoder_if.slave bus
);

   import itype_instr_encoder_pkg::*;

   enc_state_t  r_state;
   logic [31:0] r_outInstr;
   logic        r_cmdErr;

   logic        w_cmdFire;
   logic        w_legal;
   logic [31:0] w_word0;
   logic [1:0]  w_liNWords;
   logic [31:0] w_liWord0;
   logic [31:0] w_liWord1;

`ifdef ITYPE_ENC_LI_EN
   logic        r_outLast;
   logic [31:0] r_pendWord;
   logic        w_twoWords;
   logic [31:0] w_word1;
`else
   logic        w_unusedLi;
   assign w_unusedLi = ^{w_liNWords, w_liWord0, w_liWord1};
`endif

   itype_instr_encoder_li_expander u_liExpander (
      .i_imm    (bus.cmd_imm),
      .i_rt     (bus.cmd_rt),
      .o_nWords (w_liNWords),
      .o_word0  (w_liWord0),
      .o_word1  (w_liWord1)
   );

   // A held word may be replaced only in the cycle it is taken by the sink.
   assign bus.cmd_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready);
   assign w_cmdFire     = bus.cmd_valid && bus.cmd_ready;

   always_comb begin
      w_legal = 1'b1;
      w_word0 = '0;
`ifdef ITYPE_ENC_LI_EN
      w_twoWords = 1'b0;
      w_word1    = '0;
`endif
      case (itype_cmd_t'(bus.cmd_op))
         CMD_ADDIU: w_word0 = makeWord(OP_ADDIU, bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
         CMD_ANDI:  w_word0 = makeWord(OP_ANDI,  bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
         CMD_ORI:   w_word0 = makeWord(OP_ORI,   bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
         CMD_XORI:  w_word0 = makeWord(OP_XORI,  bus.cmd_rs, bus.cmd_rt, bus.cmd_imm[15:0]);
         CMD_LUI:   w_word0 = makeWord(OP_LUI,   5'd0,       bus.cmd_rt, bus.cmd_imm[15:0]);
`ifdef ITYPE_ENC_LI_EN
         CMD_LI: begin
            w_word0    = w_liWord0;
            w_word1    = w_liWord1;
            w_twoWords = (w_liNWords == 2'd2);
         end
`endif
         default:   w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_outInstr <= '0;
         r_cmdErr   <= 1'b0;
`ifdef ITYPE_ENC_LI_EN
         r_outLast  <= 1'b0;
         r_pendWord <= '0;
`endif
      end else begin
         r_cmdErr <= w_cmdFire && !w_legal;
         if (w_cmdFire && w_legal) begin
            r_outInstr <= w_word0;
`ifdef ITYPE_ENC_LI_EN
            r_outLast  <= !w_twoWords;
            r_pendWord <= w_word1;
            r_state    <= w_twoWords ? ST_HOLD2 : ST_HOLD;
`else
            r_state    <= ST_HOLD;
`endif
         end
`ifdef ITYPE_ENC_LI_EN
         else if ((r_state == ST_HOLD2) && bus.out_ready) begin
            r_outInstr <= r_pendWord;
            r_outLast  <= 1'b1;
            r_state    <= ST_HOLD;
         end
`endif
         else if (bus.out_ready) begin
            r_state <= ST_IDLE;
         end
      end
   end

   assign bus.out_valid = (r_state != ST_IDLE);
   assign bus.out_instr = r_outInstr;
   assign bus.cmd_err   = r_cmdErr;
`ifdef ITYPE_ENC_LI_EN
   assign bus.out_last  = r_outLast;
`else
   assign bus.out_last  = 1'b1;
`endif

endmodule

// File: tb/tb_itype_instr_encoder.sv
// Self-checking bench for itype_instr_encoder: directed scenarios plus a
// randomized run scored against an arithmetic reference model and word queue.
module tb_itype_instr_encoder;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   itype_instr_encoder_if bus();

   itype_instr_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] word;
      logic        last;
   } expWord_t;

   expWord_t expQ[$];

`ifdef ITYPE_ENC_LI_EN
   localparam bit LI_ON = 1'b1;
`else
   localparam bit LI_ON = 1'b0;
`endif

   function automatic logic [31:0] enc(input int opc, input int rs, input int rt, input int imm16);
      return 32'(opc * 67108864 + rs * 2097152 + rt * 65536 + imm16);
   endfunction

   // Reference: what the instruction stream must contain for one command.
   function automatic void refModel(input int op, input int rs, input int rt, input logic [31:0] imm,
                                    output bit err, output int n,
                                    output logic [31:0] w0, output logic [31:0] w1);
      int lo;
      int hi;
      lo  = int'(imm % 32'd65536);
      hi  = int'(imm / 32'd65536);
      err = 1'b0;
      n   = 1;
      w0  = '0;
      w1  = '0;
      case (op)
         0: w0 = enc(9, rs, rt, lo);
         1: w0 = enc(12, rs, rt, lo);
         2: w0 = enc(13, rs, rt, lo);
         3: w0 = enc(14, rs, rt, lo);
         4: w0 = enc(15, 0, rt, lo);
         5: begin
            if (!LI_ON) err = 1'b1;
            else if (hi == 0) w0 = enc(13, 0, rt, lo);
            else if (lo == 0) w0 = enc(15, 0, rt, hi);
            else if (imm >= 32'hFFFF8000) w0 = enc(9, 0, rt, lo);
            else begin
               n  = 2;
               w0 = enc(15, 0, rt, hi);
               w1 = enc(13, rt, rt, lo);
            end
         end
         default: err = 1'b1;
      endcase
   endfunction

   task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [31:0] imm, input logic ordy);
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_rs    = rs;
      bus.cmd_rt    = rt;
      bus.cmd_imm   = imm;
      bus.out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic expLast;
      expLast = LI_ON ? 1'b0 : 1'b1;
      reset = 1'b1;
      applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b0);
      repeat (3) tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", bus.out_valid); end
      checks++;
      if (bus.out_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr got %h expected 00000000", bus.out_instr); end
      checks++;
      if (bus.cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", bus.cmd_err); end
      checks++;
      if (bus.out_last !== expLast) begin errors++; $display("[TB] FAIL reset_last got %b expected %b", bus.out_last, expLast); end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", bus.cmd_ready); end
   endtask

   task automatic test_addiu();
      applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 32'h0000_0005, 1'b1);
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL addiu_ready got %b expected 1", bus.cmd_ready); end
      tick();
      applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addiu_valid got %b expected 1", bus.out_valid); end
      checks++;
      if (bus.out_instr !== 32'h2422_0005) begin errors++; $display("[TB] FAIL addiu_instr got %h expected 24220005", bus.out_instr); end
      checks++;
      if (bus.out_last !== 1'b1) begin errors++; $display("[TB] FAIL addiu_last got %b expected 1", bus.out_last); end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addiu_idle got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_li_pair();
      applyStimulus(1'b1, 3'd5, 5'd0, 5'd8, 32'h1234_5678, 1'b1);
      tick();
      applyStimulus(1'b1, 3'd0, 5'd1, 5'd1, 32'd1, 1'b1);
      #1;
      if (LI_ON) begin
         checks++;
         if (bus.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL li_ready_hold2 got %b expected 0", bus.cmd_ready); end
         checks++;
         if (bus.out_instr !== 32'h3C08_1234 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b1)
            begin errors++; $display("[TB] FAIL li_word0 got %h/%b/%b expected 3c081234/last0/valid1", bus.out_instr, bus.out_last, bus.out_valid); end
         applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
         tick();
         checks++;
         if (bus.out_instr !== 32'h3508_5678 || bus.out_last !== 1'b1 || bus.out_valid !== 1'b1)
            begin errors++; $display("[TB] FAIL li_word1 got %h/%b/%b expected 35085678/last1/valid1", bus.out_instr, bus.out_last, bus.out_valid); end
         tick();
      end else begin
         checks++;
         if (bus.cmd_err !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL li_disabled got err%b/valid%b expected err1/valid0", bus.cmd_err, bus.out_valid); end
         applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
         tick();
         tick();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL li_pair_idle got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_li_single();
      logic [31:0] imms [3] = '{32'h0000_BEEF, 32'hFFFF_8000, 32'hABCD_0000};
      logic [4:0]  rts  [3] = '{5'd3, 5'd4, 5'd5};
      logic [31:0] exps [3] = '{32'h3403_BEEF, 32'h2404_8000, 32'h3C05_ABCD};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'd5, 5'd31, rts[i], imms[i], 1'b1);
         tick();
         applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
         checks++;
         if (LI_ON) begin
            if (bus.out_valid !== 1'b1 || bus.out_instr !== exps[i] || bus.out_last !== 1'b1)
               begin errors++; $display("[TB] FAIL li_single%0d got %h/%b/%b expected %h/last1/valid1", i, bus.out_instr, bus.out_last, bus.out_valid, exps[i]); end
         end else begin
            if (bus.out_valid !== 1'b0 || bus.cmd_err !== 1'b1)
               begin errors++; $display("[TB] FAIL li_single%0d got valid%b/err%b expected valid0/err1", i, bus.out_valid, bus.cmd_err); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      logic [31:0] expFirst;
      logic        expFirstLast;
      if (LI_ON) begin
         applyStimulus(1'b1, 3'd5, 5'd0, 5'd8, 32'h1234_5678, 1'b0);
         expFirst     = 32'h3C08_1234;
         expFirstLast = 1'b0;
      end else begin
         applyStimulus(1'b1, 3'd2, 5'd3, 5'd4, 32'h0000_ABCD, 1'b0);
         expFirst     = 32'h3464_ABCD;
         expFirstLast = 1'b1;
      end
      tick();
      applyStimulus(1'b1, 3'd0, 5'd7, 5'd7, 32'h7, 1'b0);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== expFirst || bus.out_last !== expFirstLast || bus.cmd_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL stall_hold%0d got %h/last%b/valid%b/ready%b expected %h/last%b/valid1/ready0",
                                     c, bus.out_instr, bus.out_last, bus.out_valid, bus.cmd_ready, expFirst, expFirstLast); end
         tick();
      end
      applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
      tick();
      if (LI_ON) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h3508_5678 || bus.out_last !== 1'b1)
            begin errors++; $display("[TB] FAIL stall_word1 got %h/last%b/valid%b expected 35085678/last1/valid1", bus.out_instr, bus.out_last, bus.out_valid); end
         tick();
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'd0, 5'(i), 5'(i + 1), 32'(256 + i), 1'b1);
         #1;
         checks++;
         if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d got %b expected 1", i, bus.cmd_ready); end
         tick();
         exp = enc(9, i, i + 1, 256 + i);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_instr !== exp)
            begin errors++; $display("[TB] FAIL b2b_word%0d got %h/valid%b expected %h/valid1", i, bus.out_instr, bus.out_valid, exp); end
      end
      applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      for (int op = 6; op < 8; op++) begin
         applyStimulus(1'b1, 3'(op), 5'd1, 5'd2, 32'h1111_2222, 1'b1);
         tick();
         applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
         checks++;
         if (bus.cmd_err !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL illegal%0d_pulse got err%b/valid%b expected err1/valid0", op, bus.cmd_err, bus.out_valid); end
         tick();
         checks++;
         if (bus.cmd_err !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL illegal%0d_after got err%b/valid%b expected err0/valid0", op, bus.cmd_err, bus.out_valid); end
      end
   endtask

   task automatic test_reset_mid();
      if (LI_ON) applyStimulus(1'b1, 3'd5, 5'd0, 5'd9, 32'h1234_5678, 1'b0);
      else       applyStimulus(1'b1, 3'd0, 5'd1, 5'd9, 32'h0000_1234, 1'b0);
      tick();
      applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'd0, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL resetmid_valid got %b expected 0", bus.out_valid); end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL resetmid_pending%0d got %b/%h expected valid0", c, bus.out_valid, bus.out_instr); end
      end
   endtask

   task automatic test_random();
      bit          expErr;
      bit          err;
      bit          v;
      bit          ordy;
      bit          expReady;
      int          n;
      int          op;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      expWord_t    e;
      expErr = 1'b0;
      expQ.delete();
      for (int c = 0; c < 400; c++) begin
         v    = (c < 380) && ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 3) != 0);
         op   = int'($urandom_range(0, 7));
         rs   = 5'($urandom);
         rt   = 5'($urandom);
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 65535));
            2: imm = 32'hFFFF_8000 + 32'($urandom_range(0, 32767));
            default: imm = $urandom & 32'hFFFF_0000;
         endcase
         applyStimulus(v, 3'(op), rs, rt, imm, ordy);
         #1;
         expReady = (expQ.size() == 0) || (expQ.size() == 1 && ordy);
         checks++;
         if (bus.cmd_ready !== expReady) begin errors++; $display("[TB] FAIL rand_ready c%0d got %b expected %b", c, bus.cmd_ready, expReady); end
         if (ordy && expQ.size() > 0) void'(expQ.pop_front());
         if (v && expReady) begin
            refModel(op, int'(rs), int'(rt), imm, err, n, w0, w1);
            expErr = err;
            if (!err) begin
               e.word = w0; e.last = (n == 1); expQ.push_back(e);
               if (n == 2) begin e.word = w1; e.last = 1'b1; expQ.push_back(e); end
            end
         end else begin
            expErr = 1'b0;
         end
         tick();
         checks++;
         if (bus.cmd_err !== expErr) begin errors++; $display("[TB] FAIL rand_err c%0d got %b expected %b", c, bus.cmd_err, expErr); end
         checks++;
         if (bus.out_valid !== (expQ.size() > 0)) begin errors++; $display("[TB] FAIL rand_valid c%0d got %b expected %b", c, bus.out_valid, expQ.size() > 0); end
         if (expQ.size() > 0) begin
            checks++;
            if (bus.out_instr !== expQ[0].word || bus.out_last !== expQ[0].last)
               begin errors++; $display("[TB] FAIL rand_word c%0d got %h/last%b expected %h/last%b", c, bus.out_instr, bus.out_last, expQ[0].word, expQ[0].last); end
         end
      end
   endtask

   initial begin
      $display("[TB] start, LI expansion %0s", LI_ON ? "enabled" : "disabled");
      test_reset();
      test_addiu();
      test_li_pair();
      test_li_single();
      test_stall();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
